axi4_stream_arbiter: RTL and testbench

AXI4_STREAM_ARBITER -- requirements
Module: axi4_stream_arbiter

---
 rtl/axi4_stream_arbiter_if.sv | 45 ++++
 rtl/axi4_stream_arbiter.sv | 118 +++++++++++
 tb/tb_axi4_stream_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_stream_arbiter_if
// Brief    : Four-slave / one-master AXI4-Stream bundle with arbiter sideband.
// Revision : 1.0
// ============================================================================
interface axi4_stream_arbiter_if #(
    parameter int DATABUSWIDTH = 16,
    parameter int TDESTWIDTH   = 2
);
    logic [3:0]                    s_axis_tvalid;
    logic [3:0]                    s_axis_tready;
    logic [4*8*DATABUSWIDTH-1:0]   s_axis_tdata;
    logic [4*DATABUSWIDTH-1:0]     s_axis_tkeep;
    logic [3:0]                    s_axis_tlast;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic [8*DATABUSWIDTH-1:0]     m_axis_tdata;
    logic [DATABUSWIDTH-1:0]       m_axis_tkeep;
    logic                          m_axis_tlast;
    logic [TDESTWIDTH-1:0]         m_axis_tdest;
    logic [3:0]                    port_enable;
    logic                          busy;
    logic [1:0]                    grant_port;

    // Arbiter view: consumes the four slave streams, drives the master stream.
    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest,
        input  m_axis_tready,
        input  port_enable,
        output busy, grant_port
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest,
        output m_axis_tready,
        output port_enable,
        input  busy, grant_port
    );
endinterface
`default_nettype wire

// File: rtl/axi4_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_stream_arbiter
// Brief    : 4:1 round-robin AXI4-Stream arbiter with packet lock and a
//            registered master output stage.
// Revision : 1.0
// ============================================================================
module axi4_stream_arbiter #(
    parameter int DATABUSWIDTH = 16,
    parameter int TDESTWIDTH   = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    axi4_stream_arbiter_if.master   bus
);
    localparam int c_DATA_W = 8 * DATABUSWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PASS  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_rr_ptr;
    logic [1:0]              r_grant_port;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;
    logic [c_DATA_W-1:0]     r_m_tdata;
    logic [DATABUSWIDTH-1:0] r_m_tkeep;
    logic [TDESTWIDTH-1:0]   r_m_tdest;

    logic [3:0]              w_req;
    logic [1:0]              w_pick;
    logic [1:0]              w_idx;
    logic                    w_found;
    logic                    w_sink_ready;
    logic                    w_accept;
    logic [c_DATA_W-1:0]     w_sel_data;
    logic [DATABUSWIDTH-1:0] w_sel_keep;
    logic                    w_sel_last;

    assign w_req = bus.s_axis_tvalid & bus.port_enable;

    // Scan from rr_ptr+3 down to rr_ptr so the last hit is the nearest one.
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = r_rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_rr_ptr + 2'(i);
            if (w_req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_sel_data   = bus.s_axis_tdata[int'(r_grant_port) * c_DATA_W +: c_DATA_W];
    assign w_sel_keep   = bus.s_axis_tkeep[int'(r_grant_port) * DATABUSWIDTH +: DATABUSWIDTH];
    assign w_sel_last   = bus.s_axis_tlast[r_grant_port];
    assign w_sink_ready = ~r_m_tvalid | bus.m_axis_tready;
    assign w_accept     = (r_state == ST_PASS) && w_sink_ready && bus.s_axis_tvalid[r_grant_port];

    assign bus.s_axis_tready = ((r_state == ST_PASS) && w_sink_ready) ? (4'b0001 << r_grant_port)
                                                                      : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= 2'd0;
            r_grant_port <= 2'd0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tkeep    <= '0;
            r_m_tdest    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_port <= w_pick;
                        r_state      <= ST_GRANT;
                    end
                end
                ST_GRANT: r_state <= ST_PASS;
                ST_PASS: begin
                    // Grant is held until the granted port's tlast is taken.
                    if (w_accept && w_sel_last) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= r_grant_port + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_sel_data;
                r_m_tkeep  <= w_sel_keep;
                r_m_tlast  <= w_sel_last;
                r_m_tdest  <= TDESTWIDTH'(r_grant_port);
            end else if (bus.m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign bus.m_axis_tvalid = r_m_tvalid;
    assign bus.m_axis_tdata  = r_m_tdata;
    assign bus.m_axis_tkeep  = r_m_tkeep;
    assign bus.m_axis_tlast  = r_m_tlast;
    assign bus.m_axis_tdest  = r_m_tdest;
    assign bus.busy          = (r_state != ST_IDLE) | r_m_tvalid;
    assign bus.grant_port    = r_grant_port;

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_stream_arbiter
// Brief    : Directed scoreboard bench for axi4_stream_arbiter.
// Revision : 1.0
// ============================================================================
module tb_axi4_stream_arbiter;
    localparam int c_DBW = 16;
    localparam int c_DW  = 8 * c_DBW;

    typedef struct packed {
        logic [c_DW-1:0]  data;
        logic [c_DBW-1:0] keep;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [c_DW-1:0]  data;
        logic [c_DBW-1:0] keep;
        logic             last;
        logic [1:0]       dest;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    beat_t src_q[4][$];
    exp_t  sb_q[$];

    axi4_stream_arbiter_if #(.DATABUSWIDTH(c_DBW), .TDESTWIDTH(2)) bus ();

    axi4_stream_arbiter #(.DATABUSWIDTH(c_DBW), .TDESTWIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t make_beat(input int n, input int k, input logic [c_DW-1:0] base);
        beat_t b;
        b.data = base + c_DW'(k);
        b.keep = (k == n - 1) ? 16'h00FF : 16'hFFFF;
        b.last = (k == n - 1);
        return b;
    endfunction

    task automatic expect_pkt(input int p, input int n, input int n_exp, input logic [c_DW-1:0] base);
        beat_t b;
        for (int k = 0; k < n_exp; k++) begin
            b = make_beat(n, k, base);
            sb_q.push_back({b.data, b.keep, b.last, 2'(p)});
        end
    endtask

    task automatic send(input int p, input int n, input int n_exp, input logic [c_DW-1:0] base);
        for (int k = 0; k < n; k++) src_q[p].push_back(make_beat(n, k, base));
        expect_pkt(p, n, n_exp, base);
    endtask

    task automatic flush();
        for (int p = 0; p < 4; p++) src_q[p].delete();
        sb_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.m_axis_tready = 1'b1;
        bus.port_enable   = 4'hF;
        flush();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_sb_size(input string name, input int target);
        for (int i = 0; i < 500 && sb_q.size() > target; i++) begin
            @(negedge clk);
            #1;
        end
        chk(name, 160'(sb_q.size()), 160'(target));
    endtask

    // Source models: a beat is retired when the DUT saw tvalid & tready.
    initial begin
        logic [3:0] fire;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = '0;
        forever begin
            @(negedge clk);
            fire = bus.s_axis_tvalid & bus.s_axis_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < 4; p++) begin
                if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    bus.s_axis_tvalid[p] = 1'b1;
                    bus.s_axis_tdata[p*c_DW +: c_DW]   = src_q[p][0].data;
                    bus.s_axis_tkeep[p*c_DBW +: c_DBW] = src_q[p][0].keep;
                    bus.s_axis_tlast[p] = src_q[p][0].last;
                end else begin
                    bus.s_axis_tvalid[p] = 1'b0;
                    bus.s_axis_tlast[p]  = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pop on each master handshake, plus hold-stability.
    initial begin
        exp_t e;
        exp_t held;
        bit   have_hold = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_hold = 0;
            end else begin
                if (have_hold && bus.m_axis_tvalid)
                    chk("hold_stable", {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tdest}, held);
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (sb_q.size() == 0) begin
                        chk("extra_beat", 160'(bus.m_axis_tdata), 160'(0) - 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("beat", {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tdest}, e);
                    end
                end
                have_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
                held = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tdest};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        bus.m_axis_tready = 1'b1;
        bus.port_enable   = 4'hF;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 160'(bus.m_axis_tvalid), 160'(0));
        chk("rst_tdata",  160'(bus.m_axis_tdata), 160'(0));
        chk("rst_misc",   160'({bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tdest}), 160'(0));
        chk("rst_sready", 160'(bus.s_axis_tready), 160'(0));
        chk("rst_busy_grant", 160'({bus.busy, bus.grant_port}), 160'(0));

        // Single port 2, three beats, latency and back-to-back beats
        do_reset();
        @(posedge clk);
        send(2, 3, 3, 128'hA);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.m_axis_tvalid) break;
        end
        chk("latency", 160'(lat), 160'(4));
        cnt = 1;
        repeat (2) begin
            @(negedge clk);
            if (bus.m_axis_tvalid) cnt++;
        end
        chk("consecutive", 160'(cnt), 160'(3));
        chk("grant_p2", 160'(bus.grant_port), 160'(2));
        wait_sb_size("drain_single", 0);

        // Fairness: order 0,1,2,3,0,1
        do_reset();
        @(posedge clk);
        send(0, 1, 1, 128'h100);
        send(1, 1, 1, 128'h110);
        send(2, 1, 1, 128'h120);
        send(3, 1, 1, 128'h130);
        send(0, 1, 1, 128'h140);
        send(1, 1, 1, 128'h150);
        wait_sb_size("drain_fair", 0);

        // Packet lock: port 0 four beats, port 1 waits
        do_reset();
        @(posedge clk);
        send(0, 4, 4, 128'h200);
        send(1, 1, 1, 128'h300);
        wait_sb_size("drain_lock", 0);

        // Backpressure for five cycles mid-packet
        do_reset();
        @(posedge clk);
        send(1, 6, 6, 128'h400);
        wait_sb_size("bp_two_out", 4);
        @(posedge clk);
        #1 bus.m_axis_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_sready", 160'(bus.s_axis_tready), 160'(0));
            chk("bp_mvalid", 160'(bus.m_axis_tvalid), 160'(1));
        end
        @(posedge clk);
        #1 bus.m_axis_tready = 1'b1;
        wait_sb_size("drain_bp", 0);

        // Mask: 1011 with ports 2 and 3 requesting
        do_reset();
        @(posedge clk);
        bus.port_enable = 4'b1011;
        send(2, 2, 0, 128'h500);
        send(3, 3, 3, 128'h600);
        wait_sb_size("mask_first", 2);
        @(posedge clk);
        #1 bus.port_enable = 4'b0011;
        wait_sb_size("mask_p3_done", 0);
        repeat (10) @(negedge clk);
        chk("mask_no_p2_valid", 160'(bus.m_axis_tvalid), 160'(0));
        chk("mask_grant", 160'(bus.grant_port), 160'(3));
        chk("mask_sready", 160'(bus.s_axis_tready), 160'(0));
        chk("mask_busy", 160'(bus.busy), 160'(0));
        @(posedge clk);
        bus.port_enable = 4'hF;
        expect_pkt(2, 2, 2, 128'h500);
        wait_sb_size("drain_mask", 0);

        // Reset on beat 2 of 4, then ports 0 and 3 request
        do_reset();
        @(posedge clk);
        send(2, 4, 2, 128'h700);
        wait_sb_size("rst_two_out", 0);
        reset = 1'b1;
        #1;
        chk("arst_tvalid", 160'(bus.m_axis_tvalid), 160'(0));
        chk("arst_tdata",  160'(bus.m_axis_tdata), 160'(0));
        chk("arst_misc",   160'({bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tdest}), 160'(0));
        chk("arst_sready", 160'(bus.s_axis_tready), 160'(0));
        chk("arst_busy_grant", 160'({bus.busy, bus.grant_port}), 160'(0));
        flush();
        repeat (2) @(posedge clk);
        send(0, 1, 1, 128'h900);
        send(3, 1, 1, 128'h800);
        #2 reset = 1'b0;
        wait_sb_size("drain_after_rst", 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
